// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: data memory for the single-cycle MIPS core.
// Decodes a global data page (0x1001_0xxx), a downward-growing stack page
// (0x7FFF_Fxxx) and a peripheral page (0x4000_0xxx) forwarded to an external
// block. Supports byte/halfword/word access with sign/zero extension and a
// sticky fault-capture register for misaligned or unmapped accesses.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   rd, wr, addr, size         access strobes, byte address, access size
//   sign_ext, wdata            sub-word read extension, write data (low-aligned)
//   rdata, accessable          combinational read data / access-ok flag
//   peri_rd, peri_wr           strobes qualified to the peripheral window
//   peri_rdata, peri_racc,
//   peri_wacc                  peripheral read data and accept handshakes
//   fault_clear                clears fault_valid and fault_cnt
//   fault_valid, fault_addr,
//   fault_kind, fault_cnt      registered fault capture state
module data_mem_ctrl #(
  parameter int unsigned GLOBAL_WORDS = 32,
  parameter int unsigned STACK_WORDS  = 32,
  parameter int unsigned FAULT_CNT_W  = 8,
  parameter logic [31:0] POISON       = 32'hCDCDCDCD
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   rd,
  input  logic                   wr,
  input  logic [31:0]            addr,
  input  logic [1:0]             size,
  input  logic                   sign_ext,
  input  logic [31:0]            wdata,
  output logic [31:0]            rdata,
  output logic                   accessable,
  output logic                   peri_rd,
  output logic                   peri_wr,
  input  logic [31:0]            peri_rdata,
  input  logic                   peri_racc,
  input  logic                   peri_wacc,
  input  logic                   fault_clear,
  output logic                   fault_valid,
  output logic [31:0]            fault_addr,
  output logic [1:0]             fault_kind,
  output logic [FAULT_CNT_W-1:0] fault_cnt
);

  localparam int unsigned STACK_BASE = 1024 - STACK_WORDS;
  localparam int unsigned GA_W = (GLOBAL_WORDS > 1) ? $clog2(GLOBAL_WORDS) : 1;
  localparam int unsigned SA_W = (STACK_WORDS > 1) ? $clog2(STACK_WORDS) : 1;

  localparam logic [19:0] PAGE_GLOBAL = 20'h10010;
  localparam logic [19:0] PAGE_STACK  = 20'h7FFFF;
  localparam logic [19:0] PAGE_PERI   = 20'h40000;

  logic [31:0] gmem [GLOBAL_WORDS];
  logic [31:0] smem [STACK_WORDS];

  logic [9:0]      word_idx;
  logic            is_glob, is_stack, is_peri;
  logic            glob_map, stack_map, mapped;
  logic            word_ok, aligned, peri_ok, strobe, acc, fault;
  logic [GA_W-1:0] g_idx;
  logic [SA_W-1:0] s_idx;
  logic [31:0]     mem_word, src_word, rd_ext;
  logic [7:0]      byte_v;
  logic [15:0]     half_v;
  logic [3:0]      be;
  logic [31:0]     wlane, wmask, merged;
  logic            mem_we;

  logic                   fault_valid_q, fault_valid_d;
  logic [31:0]            fault_addr_q, fault_addr_d;
  logic [1:0]             fault_kind_q, fault_kind_d;
  logic [FAULT_CNT_W-1:0] fault_cnt_q, fault_cnt_d;

  // Page and region decode
  always_comb begin
    word_idx  = addr[11:2];
    is_glob   = (addr[31:12] == PAGE_GLOBAL);
    is_stack  = (addr[31:12] == PAGE_STACK);
    is_peri   = (addr[31:12] == PAGE_PERI);
    glob_map  = is_glob  && (32'(word_idx) <  GLOBAL_WORDS);
    stack_map = is_stack && (32'(word_idx) >= STACK_BASE);
    mapped    = glob_map || stack_map || is_peri;
    g_idx     = GA_W'(word_idx);
    s_idx     = SA_W'(32'(word_idx) - STACK_BASE);
  end

  // Alignment check; the peripheral window only takes aligned words
  always_comb begin
    word_ok = (size == 2'b10) && (addr[1:0] == 2'b00);
    case (size)
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = ~addr[0];
      2'b10:   aligned = (addr[1:0] == 2'b00);
      default: aligned = 1'b0;
    endcase
    if (is_peri) aligned = word_ok;
  end

  // Access qualification and fault detection
  always_comb begin
    strobe  = rd || wr;
    peri_ok = (!rd || peri_racc) && (!wr || peri_wacc);
    acc     = strobe && aligned && mapped && (!is_peri || peri_ok);
    fault   = strobe && !acc;
  end

  assign accessable = acc;
  assign peri_rd    = rd && is_peri && word_ok;
  assign peri_wr    = wr && is_peri && word_ok;

  // Read path: pick source word, shift the lane down, extend
  always_comb begin
    mem_word = is_glob ? gmem[g_idx] : smem[s_idx];
    src_word = is_peri ? peri_rdata : mem_word;
    case (addr[1:0])
      2'b00:   byte_v = src_word[7:0];
      2'b01:   byte_v = src_word[15:8];
      2'b10:   byte_v = src_word[23:16];
      default: byte_v = src_word[31:24];
    endcase
    half_v = addr[1] ? src_word[31:16] : src_word[15:0];
    case (size)
      2'b00:   rd_ext = {{24{sign_ext & byte_v[7]}}, byte_v};
      2'b01:   rd_ext = {{16{sign_ext & half_v[15]}}, half_v};
      default: rd_ext = src_word;
    endcase
  end

  assign rdata = (rd && acc) ? rd_ext : POISON;

  // Write path: byte enables, replicated lane data, merge with old word
  always_comb begin
    case (size)
      2'b00: begin
        be    = 4'b0001 << addr[1:0];
        wlane = {4{wdata[7:0]}};
      end
      2'b01: begin
        be    = addr[1] ? 4'b1100 : 4'b0011;
        wlane = {2{wdata[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wlane = wdata;
      end
    endcase
    wmask  = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    merged = (mem_word & ~wmask) | (wlane & wmask);
    mem_we = wr && acc && !is_peri && !reset;
  end

  // Memory arrays are not reset; contents come from the simulation preload
  always_ff @(posedge clk) begin
    if (mem_we && glob_map) gmem[g_idx] <= merged;
  end

  always_ff @(posedge clk) begin
    if (mem_we && stack_map) smem[s_idx] <= merged;
  end

  // Fault capture next state: clear first, then a same-cycle fault re-captures
  always_comb begin
    fault_valid_d = fault_valid_q;
    fault_addr_d  = fault_addr_q;
    fault_kind_d  = fault_kind_q;
    fault_cnt_d   = fault_cnt_q;
    if (fault_clear) begin
      fault_valid_d = 1'b0;
      fault_cnt_d   = '0;
    end
    if (fault) begin
      if (!fault_valid_d) begin
        fault_addr_d = addr;
        fault_kind_d = {wr, ~aligned};
      end
      fault_valid_d = 1'b1;
      if (fault_cnt_d != '1) fault_cnt_d = fault_cnt_d + FAULT_CNT_W'(1);
    end
  end

  // Fault capture registers
  always_ff @(posedge clk) begin
    if (reset) begin
      fault_valid_q <= 1'b0;
      fault_addr_q  <= '0;
      fault_kind_q  <= '0;
      fault_cnt_q   <= '0;
    end else begin
      fault_valid_q <= fault_valid_d;
      fault_addr_q  <= fault_addr_d;
      fault_kind_q  <= fault_kind_d;
      fault_cnt_q   <= fault_cnt_d;
    end
  end

  assign fault_valid = fault_valid_q;
  assign fault_addr  = fault_addr_q;
  assign fault_kind  = fault_kind_q;
  assign fault_cnt   = fault_cnt_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Testbench for data_mem_ctrl: a byte-addressed reference model predicts
// every cycle's outputs into a queue; a negedge monitor pops and compares.
module tb_data_mem_ctrl;

  localparam int unsigned GW = 32;
  localparam int unsigned SW = 32;
  localparam int unsigned CW = 8;
  localparam logic [31:0] POISON = 32'hCDCDCDCD;

  logic          clk = 1'b0;
  logic          reset, rd, wr, sign_ext, fault_clear;
  logic [31:0]   addr, wdata, peri_rdata;
  logic [1:0]    size;
  logic          peri_racc, peri_wacc;
  logic [31:0]   rdata, fault_addr;
  logic          accessable, peri_rd, peri_wr, fault_valid;
  logic [1:0]    fault_kind;
  logic [CW-1:0] fault_cnt;

  always #5 clk = ~clk;

  data_mem_ctrl #(
    .GLOBAL_WORDS(GW), .STACK_WORDS(SW), .FAULT_CNT_W(CW), .POISON(POISON)
  ) dut (
    .clk(clk), .reset(reset), .rd(rd), .wr(wr), .addr(addr), .size(size),
    .sign_ext(sign_ext), .wdata(wdata), .rdata(rdata), .accessable(accessable),
    .peri_rd(peri_rd), .peri_wr(peri_wr), .peri_rdata(peri_rdata),
    .peri_racc(peri_racc), .peri_wacc(peri_wacc), .fault_clear(fault_clear),
    .fault_valid(fault_valid), .fault_addr(fault_addr), .fault_kind(fault_kind),
    .fault_cnt(fault_cnt)
  );

  typedef struct {
    logic [31:0]   rdata;
    logic          acc;
    logic          prd;
    logic          pwr;
    logic          fv;
    logic [31:0]   fa;
    logic [1:0]    fk;
    logic [CW-1:0] fc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state
  logic [7:0]    bmem [logic [31:0]];
  logic          m_fv = 1'b0;
  logic [31:0]   m_fa = '0;
  logic [1:0]    m_fk = '0;
  logic [CW-1:0] m_fc = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: outputs are settled by the falling edge
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("rdata", rdata, e.rdata);
      chk("accessable", 32'(accessable), 32'(e.acc));
      chk("peri_rd", 32'(peri_rd), 32'(e.prd));
      chk("peri_wr", 32'(peri_wr), 32'(e.pwr));
      chk("fault_valid", 32'(fault_valid), 32'(e.fv));
      chk("fault_addr", fault_addr, e.fa);
      chk("fault_kind", 32'(fault_kind), 32'(e.fk));
      chk("fault_cnt", 32'(fault_cnt), 32'(e.fc));
    end
  end

  // One clock of stimulus: drive, predict, push, advance model past the edge
  task automatic cycle(input logic i_rst, input logic i_rd, input logic i_wr,
                       input logic [31:0] i_addr, input logic [1:0] i_size,
                       input logic i_sx, input logic [31:0] i_wdata,
                       input logic i_fclr, input logic [31:0] i_prdata,
                       input logic i_pracc, input logic i_pwacc);
    longint      a;
    int          n;
    bit          peri, gmap, smap, aligned, mapped, acc, flt;
    logic [31:0] v;
    exp_t        e;
    reset = i_rst; rd = i_rd; wr = i_wr; addr = i_addr; size = i_size;
    sign_ext = i_sx; wdata = i_wdata; fault_clear = i_fclr;
    peri_rdata = i_prdata; peri_racc = i_pracc; peri_wacc = i_pwacc;

    a    = longint'(i_addr);
    n    = (i_size == 2'd3) ? 0 : (1 << i_size);
    peri = (a >= 64'h4000_0000) && (a < 64'h4000_1000);
    gmap = (a >= 64'h1001_0000) && (a < 64'h1001_0000 + 4 * GW);
    smap = (a >= 64'h8000_0000 - 4 * SW) && (a < 64'h8000_0000);
    aligned = 1'b0;
    if (n != 0) aligned = ((a % n) == 0) && (!peri || n == 4);
    mapped = gmap || smap || peri;
    acc = (i_rd || i_wr) && aligned && mapped &&
          (!peri || ((!i_rd || i_pracc) && (!i_wr || i_pwacc)));
    flt = (i_rd || i_wr) && !acc;

    v = '0;
    if (acc) begin
      if (peri) v = i_prdata;
      else for (int i = 0; i < n; i++) v[8*i +: 8] = bmem[i_addr + 32'(i)];
      if (i_sx && n == 1 && v[7])  v[31:8]  = '1;
      if (i_sx && n == 2 && v[15]) v[31:16] = '1;
    end
    e.rdata = (i_rd && acc) ? v : POISON;
    e.acc = acc;
    e.prd = i_rd && peri && aligned;
    e.pwr = i_wr && peri && aligned;
    e.fv = m_fv; e.fa = m_fa; e.fk = m_fk; e.fc = m_fc;
    exp_q.push_back(e);

    if (i_rst) begin
      m_fv = 1'b0; m_fa = '0; m_fk = '0; m_fc = '0;
    end else begin
      if (i_fclr) begin
        m_fv = 1'b0; m_fc = '0;
      end
      if (flt) begin
        if (!m_fv) begin
          m_fa = i_addr;
          m_fk = {i_wr, !aligned};
        end
        m_fv = 1'b1;
        if (int'(m_fc) < (1 << CW) - 1) m_fc = m_fc + 1'b1;
      end
      if (i_wr && acc && !peri)
        for (int i = 0; i < n; i++) bmem[i_addr + 32'(i)] = i_wdata[8*i +: 8];
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wr_op(input logic [31:0] a, input logic [1:0] s, input logic [31:0] d);
    cycle(1'b0, 1'b0, 1'b1, a, s, 1'b0, d, 1'b0, $urandom, 1'b1, 1'b1);
  endtask

  task automatic rd_op(input logic [31:0] a, input logic [1:0] s, input logic sx);
    cycle(1'b0, 1'b1, 1'b0, a, s, sx, $urandom, 1'b0, $urandom, 1'b1, 1'b1);
  endtask

  function automatic logic [31:0] rand_addr();
    int sel;
    sel = $urandom_range(0, 9);
    if (sel <= 3)      return 32'h1001_0000 + $urandom_range(0, 4 * GW + 15);
    else if (sel <= 6) return 32'h8000_0000 - $urandom_range(1, 4 * SW + 16);
    else if (sel <= 8) return 32'h4000_0000 + $urandom_range(0, 63);
    else               return $urandom;
  endfunction

  initial begin
    reset = 1'b1; rd = 1'b0; wr = 1'b0; addr = '0; size = 2'b10; sign_ext = 1'b0;
    wdata = '0; fault_clear = 1'b0; peri_rdata = '0; peri_racc = 1'b1; peri_wacc = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Preload every mapped word so all later reads are defined
    for (int i = 0; i < int'(GW); i++) wr_op(32'h1001_0000 + 32'(4 * i), 2'b10, $urandom);
    for (int i = 0; i < int'(SW); i++) wr_op(32'h8000_0000 - 32'(4 * SW) + 32'(4 * i), 2'b10, $urandom);

    // Word / byte / halfword access and extension
    wr_op(32'h1001_0008, 2'b10, 32'h1122_3344);
    rd_op(32'h1001_0008, 2'b10, 1'b0);
    wr_op(32'h1001_000A, 2'b00, 32'h0000_00AA);
    rd_op(32'h1001_0008, 2'b10, 1'b0);
    rd_op(32'h1001_000A, 2'b00, 1'b1);
    rd_op(32'h1001_000A, 2'b00, 1'b0);
    rd_op(32'h1001_0008, 2'b01, 1'b1);
    rd_op(32'h1001_000A, 2'b01, 1'b1);
    rd_op(32'h1001_0009, 2'b01, 1'b1);
    rd_op(32'h1001_0008, 2'b11, 1'b0);

    // Stack region edges and just-below-mapped address
    wr_op(32'h7FFF_FFFC, 2'b10, 32'hCAFE_F00D);
    wr_op(32'h7FFF_FF80, 2'b10, 32'h0BAD_BEEF);
    rd_op(32'h7FFF_FFFC, 2'b10, 1'b0);
    rd_op(32'h7FFF_FF80, 2'b10, 1'b0);
    rd_op(32'h7FFF_FF7C, 2'b10, 1'b0);
    rd_op(32'h1001_0000 + 32'(4 * GW), 2'b10, 1'b0);

    // Peripheral window: accepted, refused, sub-word
    cycle(1'b1, 1'b0, 1'b0, '0, 2'b10, 1'b0, '0, 1'b0, '0, 1'b1, 1'b1);
    wr_op(32'h4000_0010, 2'b10, 32'h5555_AAAA);
    wr_op(32'h4000_0010, 2'b00, 32'h0000_0077);
    cycle(1'b0, 1'b1, 1'b0, 32'h4000_0010, 2'b10, 1'b0, '0, 1'b0, 32'h8765_4321, 1'b1, 1'b1);
    cycle(1'b0, 1'b1, 1'b0, 32'h4000_0014, 2'b10, 1'b0, '0, 1'b1, 32'h8765_4321, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 32'h4000_0018, 2'b10, 1'b0, '0, 1'b1, '0, 1'b1, 1'b0);

    // Read and write in the same cycle shows pre-write contents
    cycle(1'b0, 1'b1, 1'b1, 32'h1001_0010, 2'b10, 1'b0, 32'hFACE_B00C, 1'b0, '0, 1'b1, 1'b1);
    rd_op(32'h1001_0010, 2'b10, 1'b0);

    // Write during reset must not land
    cycle(1'b1, 1'b0, 1'b1, 32'h1001_0008, 2'b10, 1'b0, 32'hDEAD_BEEF, 1'b0, '0, 1'b1, 1'b1);
    rd_op(32'h1001_0008, 2'b10, 1'b0);

    // Three faults, then clear together with a fourth
    rd_op(32'h2000_0000, 2'b10, 1'b0);
    rd_op(32'h2000_0004, 2'b10, 1'b0);
    wr_op(32'h1001_0001, 2'b10, 32'h1);
    cycle(1'b0, 1'b1, 1'b0, 32'h3000_0004, 2'b10, 1'b0, '0, 1'b1, '0, 1'b1, 1'b1);
    rd_op(32'h1001_0000, 2'b10, 1'b0);

    // Counter saturation
    for (int i = 0; i < 300; i++) rd_op(32'h2000_0000 + 32'(4 * i), 2'b10, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, '0, 2'b10, 1'b0, '0, 1'b1, '0, 1'b1, 1'b1);

    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      int r, s;
      logic [1:0] sz;
      r = $urandom_range(0, 3);
      s = $urandom_range(0, 7);
      sz = (s <= 1) ? 2'd0 : (s <= 3) ? 2'd1 : (s <= 6) ? 2'd2 : 2'd3;
      cycle(($urandom_range(0, 99) == 0), r[0], r[1], rand_addr(), sz,
            1'($urandom), $urandom, ($urandom_range(0, 19) == 0), $urandom,
            ($urandom_range(0, 5) != 0), ($urandom_range(0, 5) != 0));
    end

    rd = 1'b0; wr = 1'b0; fault_clear = 1'b0; reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
- Parametrised next-generation data memory for the single-cycle MIPS core. Decodes three windows:
  - global data page 0x1001_0xxx
  - stack page 0x7FFF_Fxxx
  - peripheral page 0x4000_0xxx, forwarded to an external peripheral block
- Adds byte and halfword access with sign/zero extension, configurable region depths, and a sticky fault-capture register for misaligned or unmapped accesses.

Parameters:
- GLOBAL_WORDS, 32, words in global region starting at 0x1001_0000; range 1..1024
- STACK_WORDS, 32, words in stack region ending at 0x7FFF_FFFC and growing downward; range 1..1024
- FAULT_CNT_W, 8, width of saturating fault counter
- POISON, 32'hCDCDCDCD, rdata value for any non-accessible read

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- rd  in  1  read strobe
- wr  in  1  write strobe
- addr  in  32  byte address
- size  in  2  access size: 00 byte, 01 halfword, 10 word, 11 reserved (treated as misaligned)
- sign_ext  in  1  1 = sign-extend sub-word reads, 0 = zero-extend
- wdata  in  32  write data; sub-word data in the low bits
- rdata  out  32  read data (combinational)
- accessable  out  1  1 = current access is aligned and mapped (combinational)
- peri_rd  out  1  rd qualified to peripheral window
- peri_wr  out  1  wr qualified to peripheral window
- peri_rdata  in  32  peripheral read data
- peri_racc  in  1  peripheral read accepted
- peri_wacc  in  1  peripheral write accepted
- fault_clear  in  1  clears fault_valid and fault_cnt
- fault_valid  out  1  sticky: a fault has been captured
- fault_addr  out  32  address of first captured fault
- fault_kind  out  2  bit1 = was write, bit0 = 1 misaligned / 0 unmapped
- fault_cnt  out  FAULT_CNT_W  saturating count of faulting cycles

Behaviour:
- Page decode on addr[31:12]:
  - 0x10010 = global
  - 0x7FFFF = stack
  - 0x40000 = peripheral
  - anything else = unmapped
- Word index is w = addr[11:2].
  - Global is mapped iff w < GLOBAL_WORDS.
  - Stack is mapped iff w >= 1024-STACK_WORDS; physical slot is w-(1024-STACK_WORDS).
- Alignment:
  - byte: any address
  - halfword: addr[0]=0
  - word: addr[1:0]=0
  - size=11 is always misaligned
- Peripheral window accepts word size only. Sub-word access to the peripheral window is misaligned.
- Byte lanes are little-endian: byte offset 0 maps to bits 7:0, halfword offset 2 maps to bits 31:16.
- accessable:
  - memory regions: aligned & mapped
  - peripheral: aligned & (rd ? peri_racc : 1) & (wr ? peri_wacc : 1)
  - 0 whenever rd=wr=0
- peri_rd / peri_wr = strobe & peripheral page & word aligned. Combinational, no added latency.
- Read path is combinational, zero latency.
  - Selected lane is shifted to bit 0, then sign- or zero-extended per sign_ext.
  - rdata = POISON when not accessable or rd=0.
- Write path:
  - On clk rise with wr & accessable & memory region, write only the addressed byte lanes.
  - Other lanes of the word are preserved.
  - Peripheral writes are carried only by peri_wr.
- rd and wr in the same cycle: rdata shows pre-write contents; the write commits at the edge.
- Fault detection: a cycle with (rd|wr) & !accessable is a fault cycle.
  - Misaligned takes priority over unmapped in fault_kind.
  - For a peripheral refusal (aligned but peri_racc or peri_wacc low), fault_kind[0]=0.
  - fault_kind[1] = wr.
- Fault capture at the edge:
  - If fault_valid=0, capture addr and fault_kind and set fault_valid.
  - If fault_valid=1, keep the first capture.
  - fault_cnt increments each fault cycle and saturates at all-ones.
- fault_clear in the same cycle as a fault: clear wins for fault_valid and fault_cnt, then that fault is captured. Result: fault_valid=1, fault_cnt=1, new address.
- Memory writes are suppressed on any fault cycle.
- Reset:
  - fault_valid=0, fault_addr=0, fault_kind=0, fault_cnt=0.
  - Memory contents are not reset; they are preloaded by the simulation init file.
- Reset mid-access: a wr asserted in the reset cycle does not write.
- Combinational outputs follow inputs during reset: rdata, accessable, peri_rd, peri_wr.

Test Plan:
- Word write 0x11223344 @0x10010008, then word read -> rdata=0x11223344, accessable=1.
- Byte write 0xAA @0x1001000A, then word read -> 0x11AA3344. Signed byte read @0x1001000A -> 0xFFFFFFAA; unsigned -> 0x000000AA.
- Halfword signed read @0x10010008 of 0x11AA3344 -> 0x00003344. Halfword read @0x10010009 -> accessable=0, rdata=0xCDCDCDCD, then fault_valid=1, fault_addr=0x10010009, fault_kind=01.
- Stack write to 0x7FFFFFFC and to 0x7FFFFF80 (with STACK_WORDS=32), read back -> data correct. Read 0x7FFFFF7C -> unmapped fault, kind=00.
- Word write @0x40000010 with peri_wacc=1 -> peri_wr=1, no memory write. Byte write there -> peri_wr=0, fault kind=11.
- Three consecutive faults, then fault_clear asserted together with a fourth fault -> fault_cnt=1, fault_addr=the fourth address. FAULT_CNT_W=2 with 5 faults -> fault_cnt=3.
